pipelined_addsub: RTL
=====================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined ripple-carry add/subtract unit.
//  Successor to the fixed 4-bit structural adder.
//  Splits a WIDTH-bit operation into STAGES equal chunks, with a registered carry between chunks.
//  Elastic valid/ready on both sides; shared arithmetic datapath for the ALU and the accumulator blocks.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = number of carry chunks (1..WIDTH)
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      unit accepts beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      0: A+B+in_cin; 1: A-B (B inverted, carry-in forced 1)
//  in_cin     in   1      carry-in; ignored when in_sub=1
//  out_valid  out  1      result beat present
//  out_ready  in   1      downstream accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of MSB (for sub: 1 = no borrow)
//  out_ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Chunk width CW = WIDTH/STAGES.
//  - Pipeline advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
//  - Accept when in_valid && in_ready. When adv=0 every stage holds; nothing is lost or duplicated.
//  - Stage k (0..STAGES-1) adds chunk k of A and B' plus the carry registered by stage k-1.
//    Stage 0 uses cin' (in_sub ? 1 : in_cin). B' = in_sub ? ~in_b : in_b, computed at input.
//  - Input skew: chunk k of A and B' is delayed k stages.
//    Output de-skew: result chunk k is delayed STAGES-1-k stages.
//    All chunks of one beat leave together.
//  - Latency: exactly STAGES cycles from accept to out_valid with out_ready held high.
//    Throughput: 1 beat/cycle.
//  - Bubbles are carried, not collapsed, under global stall.
//    A per-stage valid bit travels with each beat; out_valid = valid of the last stage.
//  - Arithmetic is modulo 2^WIDTH; out_cout and out_ovf come from the final (MSB) chunk only.
//  - STAGES=1 degenerates to a single registered WIDTH-bit adder with latency 1.
//  - Reset: every stage valid = 0, every data/skew register = 0.
//    Outputs out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=1 in the first cycle after reset.
//  - Reset mid-operation discards all in-flight beats; no partial result is emitted.
//  - Simultaneous accept and emit in the same cycle is legal and required for full throughput.
//  - out_* remain stable while out_valid && !out_ready.
// STRUCTURE
//  - Shared package addsub_pkg: localparams for default WIDTH/STAGES, a CW derivation function,
//    and a mode encoding constant (ADD=1'b0, SUB=1'b1).
//  - One sub-module: addsub_chunk (CW-bit ripple of full-adder cells).
//    Outputs sum, carry out of the chunk, and carry into the chunk MSB (needed for overflow).
//    Instantiated STAGES times via generate.
//  - Skew/de-skew and valid registers live in the top; no other hierarchy.
//  - Elaboration check: WIDTH % STAGES != 0 is a fatal error.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//  1. Ripple across all chunks: 0xFFFF + 0x0001 (add, cin=0) -> out_sum=0x0000, out_cout=1, out_ovf=0.
//     out_valid asserts exactly 4 cycles after accept.
//  2. Subtract overflow: 0x8000 - 0x0001 -> out_sum=0x7FFF, out_cout=1, out_ovf=1.
//     Then 0x0000 - 0x0001 -> out_sum=0xFFFF, out_cout=0, out_ovf=0.
//  3. Chunk-boundary carry: 0x00FF + 0x0001 -> 0x0100.
//     Also 0x0FFF + 0x0000 with cin=1 -> 0x1000, out_cout=0.
//  4. Streaming with backpressure: 64 random beats back to back, out_ready toggled pseudo-randomly.
//     Results match a reference model in order; no drops or duplicates; out_* stable while stalled.
//  5. Reset mid-flight: 3 beats accepted, rst pulsed 1 cycle.
//     No out_valid for those beats; the next beat accepted emerges after 4 cycles with a correct sum.
//  6. Degenerate configs: STAGES=1 gives latency 1; WIDTH=8, STAGES=8 gives 0x7F+0x01 -> 0x80, out_ovf=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants for the pipelined add/subtract datapath: default geometry,
// chunk-width derivation and the add/subtract mode encoding.
package addsub_pkg;

   localparam int DEFAULT_WIDTH  = 16;
   localparam int DEFAULT_STAGES = 4;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CW-bit ripple of full-adder cells. Also exposes the carry into the chunk
// MSB so the top can derive signed overflow from the most significant chunk.
module addsub_chunk #(
   parameter int CW = 4
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic [CW-1:0] sum,
   output logic          cout,
   output logic          cmsb
);

   logic [CW:0] carry;

   always_comb begin
      sum      = '0;
      carry    = '0;
      carry[0] = cin;
      for (int i = 0; i < CW; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[CW];
   assign cmsb = carry[CW - 1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry add/subtract unit: WIDTH bits split into STAGES chunks
// with a registered carry between chunks and elastic valid/ready on both sides.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int CW = chunk_width(WIDTH, STAGES);

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_check
      $fatal(1, "pipelined_addsub: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Per-stage registers. a_q/b_q carry the operands forward so the upper
   // chunks arrive skewed; sum_q accumulates finished chunks (de-skew).
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] carry_q;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic              ovf_q;

   logic [WIDTH-1:0]  stage_a      [STAGES];
   logic [WIDTH-1:0]  stage_b      [STAGES];
   logic [WIDTH-1:0]  stage_sum_in [STAGES];
   logic [WIDTH-1:0]  next_sum     [STAGES];
   logic [STAGES-1:0] stage_cin;

   logic [CW-1:0]     chunk_sum  [STAGES];
   logic [STAGES-1:0] chunk_cout;
   logic              chunk_cmsb [STAGES];

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign b_eff    = (in_sub == MODE_ADD) ? in_b : ~in_b;
   assign cin_eff  = (in_sub == MODE_SUB) ? 1'b1 : in_cin;

   // Stage 0 works straight from the input port; later stages from the previous stage's registers.
   always_comb begin
      stage_a[0]      = in_a;
      stage_b[0]      = b_eff;
      stage_cin[0]    = cin_eff;
      stage_sum_in[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         stage_a[k]      = a_q[k - 1];
         stage_b[k]      = b_q[k - 1];
         stage_cin[k]    = carry_q[k - 1];
         stage_sum_in[k] = sum_q[k - 1];
      end
      for (int k = 0; k < STAGES; k++) begin
         next_sum[k]                = stage_sum_in[k];
         next_sum[k][k * CW +: CW]  = chunk_sum[k];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_chunk
      addsub_chunk #(
         .CW(CW)
      ) u_chunk (
         .a   (stage_a[k][k * CW +: CW]),
         .b   (stage_b[k][k * CW +: CW]),
         .cin (stage_cin[k]),
         .sum (chunk_sum[k]),
         .cout(chunk_cout[k]),
         .cmsb(chunk_cmsb[k])
      );
   end

   // Whole pipeline advances or holds as one; bubbles keep their slot under stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else if (adv) begin
         valid_q[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            valid_q[k] <= valid_q[k - 1];
         end
         carry_q <= chunk_cout;
         ovf_q   <= chunk_cmsb[STAGES - 1] ^ chunk_cout[STAGES - 1];
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= stage_a[k];
            b_q[k]   <= stage_b[k];
            sum_q[k] <= next_sum[k];
         end
      end
   end

   assign out_valid = valid_q[STAGES - 1];
   assign out_sum   = sum_q[STAGES - 1];
   assign out_cout  = carry_q[STAGES - 1];
   assign out_ovf   = ovf_q;

endmodule
